chan_550_pulse_writer: RTL

Pulse-record writer for the chan_550 readout path. It timestamps pulse events from the pulse detector and buffers them in a small FIFO. It serialises each event into two 32-bit words in the pulse BRAM. It also publishes the BRAM address of the last completed record as `pulses_addr`, which drives `user_data_in` of the software-readable pulses-address register. Software polls that register to find how far the writer has progressed in the circular buffer.

---
 rtl/chan_550_pulse_writer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/chan_550_pulse_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : chan_550_pulse_writer
// Purpose  : Timestamps pulse events, queues them in a FIFO, and writes each
//            one to the pulse BRAM as a two-word record.
// Revision : 1.0
// ============================================================================
module chan_550_pulse_writer #(
    parameter int ADDR_W    = 14,
    parameter int FIFO_LOG2 = 4
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              run,
    input  logic              sync_in,
    input  logic              in_valid,
    input  logic [7:0]        in_ch,
    input  logic [15:0]       in_phase,
    input  logic [15:0]       in_base,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_data,
    output logic [31:0]       pulses_addr,
    output logic [15:0]       drop_count
);

    localparam int                  c_FIFO_DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]  c_PTR_ONE    = (FIFO_LOG2+1)'(1);
    localparam logic [ADDR_W-1:0]   c_ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]   c_ADDR_TWO   = ADDR_W'(2);
    localparam logic [15:0]         c_DROP_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR0  = 2'd1,
        S_WR1  = 2'd2
    } state_t;

    state_t              r_state_q,       w_state_d;
    logic [23:0]         r_ts_q,          w_ts_d;
    logic [FIFO_LOG2:0]  r_wr_ptr_q,      w_wr_ptr_d;
    logic [FIFO_LOG2:0]  r_rd_ptr_q,      w_rd_ptr_d;
    logic [ADDR_W-1:0]   r_wa_q,          w_wa_d;
    logic [31:0]         r_word1_q,       w_word1_d;
    logic                r_bram_we_q,     w_bram_we_d;
    logic [ADDR_W-1:0]   r_bram_addr_q,   w_bram_addr_d;
    logic [31:0]         r_bram_data_q,   w_bram_data_d;
    logic [31:0]         r_pulses_addr_q, w_pulses_addr_d;
    logic [15:0]         r_drop_q,        w_drop_d;

    // Entry layout: {ch[63:56], ts[55:32], phase[31:16], base[15:0]}, so the
    // upper half is word0 and the lower half is word1.
    logic [63:0]         r_fifo_mem [c_FIFO_DEPTH];

    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [63:0]         w_head;
    logic                w_pop;
    logic                w_evt;
    logic                w_push;
    logic                w_drop;
    logic [ADDR_W-1:0]   w_wa_p1;
    logic [ADDR_W-1:0]   w_wa_p2;

    assign w_fifo_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign w_fifo_full  = (r_wr_ptr_q[FIFO_LOG2] != r_rd_ptr_q[FIFO_LOG2]) &&
                          (r_wr_ptr_q[FIFO_LOG2-1:0] == r_rd_ptr_q[FIFO_LOG2-1:0]);
    assign w_head       = r_fifo_mem[r_rd_ptr_q[FIFO_LOG2-1:0]];

    // The writer pulls a new record whenever it is free to start word0.
    assign w_pop   = !w_fifo_empty && ((r_state_q == S_IDLE) || (r_state_q == S_WR1));
    assign w_evt   = run && in_valid;
    assign w_push  = w_evt && (!w_fifo_full || w_pop);
    assign w_drop  = w_evt && !w_push;
    assign w_wa_p1 = r_wa_q + c_ADDR_ONE;
    assign w_wa_p2 = r_wa_q + c_ADDR_TWO;

    always_comb begin
        w_state_d       = r_state_q;
        w_ts_d          = sync_in ? 24'd0 : (r_ts_q + 24'd1);
        w_wr_ptr_d      = w_push ? (r_wr_ptr_q + c_PTR_ONE) : r_wr_ptr_q;
        w_rd_ptr_d      = w_pop  ? (r_rd_ptr_q + c_PTR_ONE) : r_rd_ptr_q;
        w_wa_d          = r_wa_q;
        w_word1_d       = r_word1_q;
        w_bram_we_d     = 1'b0;
        w_bram_addr_d   = r_bram_addr_q;
        w_bram_data_d   = r_bram_data_q;
        w_pulses_addr_d = r_pulses_addr_q;
        w_drop_d        = (w_drop && (r_drop_q != c_DROP_MAX)) ? (r_drop_q + 16'd1) : r_drop_q;

        case (r_state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_d     = S_WR0;
                    w_bram_we_d   = 1'b1;
                    w_bram_addr_d = r_wa_q;
                    w_bram_data_d = w_head[63:32];
                    w_word1_d     = w_head[31:0];
                end
            end
            S_WR0: begin
                w_state_d     = S_WR1;
                w_bram_we_d   = 1'b1;
                w_bram_addr_d = w_wa_p1;
                w_bram_data_d = r_word1_q;
            end
            S_WR1: begin
                // Publish only now, after word1 has actually been strobed.
                w_pulses_addr_d = {{(32-ADDR_W){1'b0}}, w_wa_p1};
                w_wa_d          = w_wa_p2;
                if (!w_fifo_empty) begin
                    w_state_d     = S_WR0;
                    w_bram_we_d   = 1'b1;
                    w_bram_addr_d = w_wa_p2;
                    w_bram_data_d = w_head[63:32];
                    w_word1_d     = w_head[31:0];
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr_q[FIFO_LOG2-1:0]] <= {in_ch, r_ts_q, in_phase, in_base};
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state_q       <= S_IDLE;
            r_ts_q          <= 24'd0;
            r_wr_ptr_q      <= '0;
            r_rd_ptr_q      <= '0;
            r_wa_q          <= '0;
            r_word1_q       <= 32'd0;
            r_bram_we_q     <= 1'b0;
            r_bram_addr_q   <= '0;
            r_bram_data_q   <= 32'd0;
            r_pulses_addr_q <= 32'd0;
            r_drop_q        <= 16'd0;
        end else begin
            r_state_q       <= w_state_d;
            r_ts_q          <= w_ts_d;
            r_wr_ptr_q      <= w_wr_ptr_d;
            r_rd_ptr_q      <= w_rd_ptr_d;
            r_wa_q          <= w_wa_d;
            r_word1_q       <= w_word1_d;
            r_bram_we_q     <= w_bram_we_d;
            r_bram_addr_q   <= w_bram_addr_d;
            r_bram_data_q   <= w_bram_data_d;
            r_pulses_addr_q <= w_pulses_addr_d;
            r_drop_q        <= w_drop_d;
        end
    end

    assign bram_we     = r_bram_we_q;
    assign bram_addr   = r_bram_addr_q;
    assign bram_data   = r_bram_data_q;
    assign pulses_addr = r_pulses_addr_q;
    assign drop_count  = r_drop_q;

endmodule
`default_nettype wire
